// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums signed rows across K-tiles into a register array,
// then drains the accumulated rows one per handshake to the normalization stage.
module psum_accumulator #(
  parameter int IN_WIDTH  = 32,
  parameter int SA_LENGTH = 256,
  parameter int DEPTH     = 256,
  parameter int CNT_WIDTH = 8
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              Start,
  input  logic [CNT_WIDTH-1:0]              TileCount,
  input  logic [$clog2(DEPTH):0]            RowCount,
  input  logic                              InValid,
  output logic                              InReady,
  input  logic [SA_LENGTH*IN_WIDTH-1:0]     InData,
  output logic                              OutValid,
  input  logic                              OutReady,
  output logic [SA_LENGTH*IN_WIDTH-1:0]     OutData,
  output logic                              OutLast,
  output logic                              Busy,
  output logic                              Done
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = SA_LENGTH * IN_WIDTH;

  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] tiles_q, tile_ptr_q, tiles_clamp;
  logic [PW-1:0]        rows_q, row_ptr_q, drain_ptr_q, rows_clamp, rows_m1;
  logic                 done_q;
  logic [RW-1:0]        acc_q [DEPTH];
  logic [RW-1:0]        acc_cur, acc_d;
  logic                 in_fire, out_fire, last_row, last_tile, drain_last;

  function automatic logic [IN_WIDTH-1:0] sat_add(input logic [IN_WIDTH-1:0] a,
                                                  input logic [IN_WIDTH-1:0] b);
    logic [IN_WIDTH:0] s;
    s = {a[IN_WIDTH-1], a} + {b[IN_WIDTH-1], b};
    // Top two bits differ only on signed overflow of the IN_WIDTH-bit result.
    if (s[IN_WIDTH] != s[IN_WIDTH-1]) begin
      return s[IN_WIDTH] ? {1'b1, {(IN_WIDTH-1){1'b0}}} : {1'b0, {(IN_WIDTH-1){1'b1}}};
    end
    return s[IN_WIDTH-1:0];
  endfunction

  always_comb begin
    tiles_clamp = (TileCount == '0) ? CNT_WIDTH'(1) : TileCount;
    if (RowCount == '0) begin
      rows_clamp = PW'(1);
    end else if (RowCount > PW'(DEPTH)) begin
      rows_clamp = PW'(DEPTH);
    end else begin
      rows_clamp = RowCount;
    end
  end

  assign rows_m1    = rows_q - PW'(1);
  assign in_fire    = (state_q == StAccum) && InValid;
  assign out_fire   = (state_q == StDrain) && OutReady;
  assign last_row   = (row_ptr_q == rows_m1);
  assign last_tile  = (tile_ptr_q == tiles_q - CNT_WIDTH'(1));
  assign drain_last = (drain_ptr_q == rows_m1);

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (Start) state_d = StAccum;
      StAccum: if (in_fire && last_row && last_tile) state_d = StDrain;
      StDrain: if (out_fire && drain_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    InReady  = (state_q == StAccum);
    OutValid = (state_q == StDrain);
    OutLast  = (state_q == StDrain) && drain_last;
    Busy     = (state_q != StIdle);
    Done     = done_q;
    OutData  = acc_q[drain_ptr_q[AW-1:0]];
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      tiles_q     <= CNT_WIDTH'(1);
      rows_q      <= PW'(1);
      row_ptr_q   <= '0;
      tile_ptr_q  <= '0;
      drain_ptr_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= out_fire && drain_last;
      unique case (state_q)
        StIdle: begin
          if (Start) begin
            tiles_q     <= tiles_clamp;
            rows_q      <= rows_clamp;
            row_ptr_q   <= '0;
            tile_ptr_q  <= '0;
            drain_ptr_q <= '0;
          end
        end
        StAccum: begin
          if (in_fire) begin
            if (last_row) begin
              row_ptr_q <= '0;
              if (last_tile) begin
                tile_ptr_q  <= '0;
                drain_ptr_q <= '0;
              end else begin
                tile_ptr_q <= tile_ptr_q + CNT_WIDTH'(1);
              end
            end else begin
              row_ptr_q <= row_ptr_q + PW'(1);
            end
          end
        end
        StDrain: begin
          if (out_fire) begin
            drain_ptr_q <= drain_last ? '0 : drain_ptr_q + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // First tile overwrites so a previous job's sums never leak in.
  always_comb begin
    acc_cur = acc_q[row_ptr_q[AW-1:0]];
    acc_d   = '0;
    for (int j = 0; j < SA_LENGTH; j++) begin
      if (tile_ptr_q == '0) begin
        acc_d[j*IN_WIDTH +: IN_WIDTH] = InData[j*IN_WIDTH +: IN_WIDTH];
      end else begin
        acc_d[j*IN_WIDTH +: IN_WIDTH] = sat_add(acc_cur[j*IN_WIDTH +: IN_WIDTH],
                                                InData[j*IN_WIDTH +: IN_WIDTH]);
      end
    end
  end

  // Buffer is not reset; contents are don't-care until written.
  always_ff @(posedge Clk) begin
    if (in_fire) begin
      acc_q[row_ptr_q[AW-1:0]] <= acc_d;
    end
  end

endmodule
